// File: rtl/fir_pkg.sv
// Shared types and constants for the myfir front-end (sample width, unfolding factor, packer phase).
package fir_pkg;
    localparam int NB = 14;
    localparam int P  = 3;

    typedef logic signed [NB-1:0] sample_t;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } phase_t;
endpackage

// File: rtl/fir_s2p_packer_if.sv
// Serial-in / 3-wide-out bus of the packer. FLUSH exists only when PACKER_FLUSH_EN is defined.
interface fir_s2p_packer_if;
    import fir_pkg::*;

    logic    VIN;
    sample_t DIN;
    logic    SYNC;
`ifdef PACKER_FLUSH_EN
    logic    FLUSH;
`endif
    sample_t DOUT0;
    sample_t DOUT1;
    sample_t DOUT2;
    logic    VOUT;

    modport master (
        output VIN, DIN, SYNC,
`ifdef PACKER_FLUSH_EN
        output FLUSH,
`endif
        input  DOUT0, DOUT1, DOUT2, VOUT
    );

    modport slave (
        input  VIN, DIN, SYNC,
`ifdef PACKER_FLUSH_EN
        input  FLUSH,
`endif
        output DOUT0, DOUT1, DOUT2, VOUT
    );
endinterface

// File: rtl/fir_s2p_packer.sv
// Packs accepted serial samples into groups of three for the unfolded FIR (DOUT0 = oldest).
// Optional macro PACKER_FLUSH_EN adds FLUSH, which emits a zero-padded partial group.
module fir_s2p_packer #(
    parameter int NB = 14,
    parameter int P  = 3
) (
    input logic             CLK,
    input logic             RST_n,
    fir_s2p_packer_if.slave bus
);
    import fir_pkg::*;

    if (P != 3 || NB != fir_pkg::NB) begin : g_bad_cfg
        $error("fir_s2p_packer supports only P=3 and NB=fir_pkg::NB");
    end

    phase_t  phase_q, phase_d, ph;
    sample_t slot0_q, slot0_d, slot1_q, slot1_d;
    sample_t dout0_q, dout0_d, dout1_q, dout1_d, dout2_q, dout2_d;
    logic    vout_q, vout_d;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            phase_q <= PH0;
            slot0_q <= '0;
            slot1_q <= '0;
            dout0_q <= '0;
            dout1_q <= '0;
            dout2_q <= '0;
            vout_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
            dout2_q <= dout2_d;
            vout_q  <= vout_d;
        end
    end

    always_comb begin
        // The unused encoding 3 falls back to PH0; SYNC forces a fresh group.
        ph = (phase_q == PH1 || phase_q == PH2) ? phase_q : PH0;
        if (bus.SYNC) ph = PH0;

        phase_d = ph;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        dout0_d = dout0_q;
        dout1_d = dout1_q;
        dout2_d = dout2_q;
        vout_d  = 1'b0;

        if (bus.VIN) begin
            unique case (ph)
                PH0: begin
                    slot0_d = bus.DIN;
                    phase_d = PH1;
                end
                PH1: begin
                    slot1_d = bus.DIN;
                    phase_d = PH2;
                end
                default: begin
                    dout0_d = slot0_q;
                    dout1_d = slot1_q;
                    dout2_d = bus.DIN;
                    vout_d  = 1'b1;
                    phase_d = PH0;
                end
            endcase
        end

`ifdef PACKER_FLUSH_EN
        // Pad after the current sample is placed; a completed group already left phase at PH0.
        if (bus.FLUSH && !bus.SYNC && phase_d != PH0) begin
            dout0_d = slot0_d;
            dout1_d = (phase_d == PH2) ? slot1_d : '0;
            dout2_d = '0;
            vout_d  = 1'b1;
            phase_d = PH0;
        end
`endif
    end

    assign bus.DOUT0 = dout0_q;
    assign bus.DOUT1 = dout1_q;
    assign bus.DOUT2 = dout2_q;
    assign bus.VOUT  = vout_q;
endmodule

// File: tb/tb_fir_s2p_packer.sv
// Scoreboard bench for fir_s2p_packer: a queue-based grouping model feeds expected groups to a monitor.
module tb_fir_s2p_packer;
    import fir_pkg::*;

    typedef struct {
        sample_t d0;
        sample_t d1;
        sample_t d2;
        int      cyc;
    } grp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_vout = 0;
    int   n_exp_grp = 0;

    grp_t    exp_q[$];
    sample_t part[$];
    grp_t    last_exp;

    fir_s2p_packer_if bus();

    fir_s2p_packer #(.NB(NB), .P(P)) dut (
        .CLK  (clk),
        .RST_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: collect accepted samples; three make a group, SYNC drops, FLUSH pads.
    task automatic model(input logic vin, input sample_t din, input logic sync, input logic flush);
        grp_t g;
        if (sync) part.delete();
        if (vin) part.push_back(din);
        g.cyc = cyc + 1;
        if (part.size() == 3) begin
            g.d0 = part[0]; g.d1 = part[1]; g.d2 = part[2];
            exp_q.push_back(g);
            n_exp_grp++;
            part.delete();
        end else if (flush && !sync && part.size() > 0) begin
            g.d0 = part[0];
            g.d1 = (part.size() > 1) ? part[1] : sample_t'(0);
            g.d2 = '0;
            exp_q.push_back(g);
            n_exp_grp++;
            part.delete();
        end
    endtask

    task automatic drive(input logic vin, input sample_t din, input logic sync, input logic flush);
        @(posedge clk);
        #1;
        bus.VIN  = vin;
        bus.DIN  = din;
        bus.SYNC = sync;
`ifdef PACKER_FLUSH_EN
        bus.FLUSH = flush;
        model(vin, din, sync, flush);
`else
        model(vin, din, sync, 1'b0);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, sample_t'($urandom), 1'b0, 1'b0);
    endtask

    // Monitor: pop on VOUT, otherwise outputs must hold the last emitted group.
    always @(negedge clk) begin
        grp_t g;
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            g = exp_q.pop_front();
            chk("missed_vout", 0, 1);
        end
        if (bus.VOUT === 1'b1) begin
            n_vout++;
            if (exp_q.size() == 0) begin
                chk("spurious_vout", 1, 0);
            end else begin
                g = exp_q.pop_front();
                chk("vout_cycle", cyc, g.cyc);
                chk("dout0", int'(bus.DOUT0), int'(g.d0));
                chk("dout1", int'(bus.DOUT1), int'(g.d1));
                chk("dout2", int'(bus.DOUT2), int'(g.d2));
                last_exp = g;
            end
        end else begin
            chk("vout_low", int'(bus.VOUT), 0);
            chk("hold0", int'(bus.DOUT0), int'(last_exp.d0));
            chk("hold1", int'(bus.DOUT1), int'(last_exp.d1));
            chk("hold2", int'(bus.DOUT2), int'(last_exp.d2));
        end
    end

    initial begin
        int nsamp;
        last_exp = '{d0: 0, d1: 0, d2: 0, cyc: 0};
        bus.VIN = 1'b0;
        bus.DIN = '0;
        bus.SYNC = 1'b0;
`ifdef PACKER_FLUSH_EN
        bus.FLUSH = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Continuous stream 1..6
        for (int i = 1; i <= 6; i++) drive(1'b1, sample_t'(i), 1'b0, 1'b0);
        idle(3);

        // Gaps inside a group
        drive(1'b1, 14'sd10, 1'b0, 1'b0);
        idle(2);
        drive(1'b1, 14'sd11, 1'b0, 1'b0);
        idle(1);
        drive(1'b1, 14'sd12, 1'b0, 1'b0);
        idle(3);

        // SYNC at phase 2 together with a sample
        drive(1'b1, 14'sd20, 1'b0, 1'b0);
        drive(1'b1, 14'sd21, 1'b0, 1'b0);
        drive(1'b1, 14'sd7,  1'b1, 1'b0);
        drive(1'b1, 14'sd8,  1'b0, 1'b0);
        drive(1'b1, 14'sd9,  1'b0, 1'b0);
        idle(3);

        // Asynchronous reset mid-group
        drive(1'b1, 14'sd30, 1'b0, 1'b0);
        drive(1'b1, 14'sd31, 1'b0, 1'b0);
        drive(1'b0, 14'sd0,  1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        part.delete();
        last_exp = '{d0: 0, d1: 0, d2: 0, cyc: 0};
        #1;
        chk("rst_vout", int'(bus.VOUT), 0);
        chk("rst_dout0", int'(bus.DOUT0), 0);
        chk("rst_dout2", int'(bus.DOUT2), 0);
        #3 rst_n = 1'b1;
        drive(1'b1, 14'sh1FFF, 1'b0, 1'b0);
        drive(1'b1, 14'sh2000, 1'b0, 1'b0);
        drive(1'b1, 14'sh3FFF, 1'b0, 1'b0);
        idle(3);

`ifdef PACKER_FLUSH_EN
        drive(1'b1, 14'sd5, 1'b0, 1'b0);
        drive(1'b1, 14'sd6, 1'b0, 1'b0);
        drive(1'b0, 14'sd0, 1'b0, 1'b1);
        drive(1'b0, 14'sd0, 1'b0, 1'b1);
        drive(1'b1, 14'sd40, 1'b0, 1'b1);
        drive(1'b1, 14'sd41, 1'b0, 1'b0);
        drive(1'b1, 14'sd42, 1'b1, 1'b1);
        drive(1'b1, 14'sd43, 1'b0, 1'b0);
        drive(1'b0, 14'sd0,  1'b0, 1'b1);
        idle(3);
`endif

        // Short random mix of SYNC/FLUSH from a clean phase
        drive(1'b0, 14'sd0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 2) != 0), sample_t'($urandom), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 14) == 0));
        drive(1'b0, 14'sd0, 1'b1, 1'b0);
        idle(3);

        // Long aligned stream: output sequence must equal input, one VOUT per three samples
        n_vout = 0;
        n_exp_grp = 0;
        nsamp = 0;
        while (nsamp < 3000) begin
            if ($urandom_range(0, 99) < 60) begin
                drive(1'b1, sample_t'($urandom), 1'b0, 1'b0);
                nsamp++;
            end else begin
                idle(1);
            end
        end
        idle(5);
        chk("stream_groups", n_exp_grp, nsamp / 3);
        chk("stream_vout_count", n_vout, nsamp / 3);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_s2p_packer.md
Name: fir_s2p_packer

Overview:
Upstream front-end of the 3-way unfolded FIR (myfir). Collects a serial stream of 14-bit samples, one per valid cycle, into groups of three. Presents each group on DOUT0/DOUT1/DOUT2 with a one-cycle VOUT strobe, which drives the FIR's DIN0..2/VIN directly. DOUT0 carries the oldest sample x[3k], DOUT1 carries x[3k+1], and DOUT2 carries x[3k+2].

Parameters:
NB, 14, sample width in bits (signed two's complement, passed through unmodified)
P, 3, unfolding factor / group size; RTL supports only P=3 (elaboration error otherwise)

Ports:
CLK  in  1  system clock, all state on rising edge
RST_n  in  1  asynchronous active-low reset
VIN  in  1  input sample valid, one sample per cycle max
DIN  in  NB  input sample, sampled when VIN=1
SYNC  in  1  synchronous group realign: discard partial group, next accepted sample becomes x[3k]
DOUT0  out  NB  oldest sample of group
DOUT1  out  NB  middle sample of group
DOUT2  out  NB  newest sample of group
VOUT  out  1  group valid, single-cycle pulse
FLUSH  in  1  present only with PACKER_FLUSH_EN; see Optional Feature

Behaviour:
- Reset: phase=0, slot0=slot1=0, DOUT0/1/2=0, VOUT=0.
- Clock and reset are fixed as decided: one clock CLK; RST_n asynchronous, active-low.
- State: 2-bit phase counter over {0,1,2}; value 3 is illegal and is treated as 0 by the next-state logic. Two holding registers, slot0 and slot1.
- VIN=1, phase=0: slot0<=DIN, phase<=1.
- VIN=1, phase=1: slot1<=DIN, phase<=2.
- VIN=1, phase=2: DOUT0<=slot0, DOUT1<=slot1, DOUT2<=DIN, VOUT<=1, phase<=0 (wrap-around).
- Latency: VOUT rises on the edge after the cycle that accepts the third sample. Throughput is one group per 3 valid cycles.
- VIN=0: phase and slots hold.
- VOUT is 1 for exactly one cycle per group. Back-to-back groups with continuous VIN give VOUT at a 1-in-3 rate.
- DOUTx hold the last group when VOUT=0. They change only together with a VOUT pulse.
- Gaps in VIN are allowed anywhere within a group; grouping is by accepted samples, not by cycles.
- SYNC=1: phase<=0; slot contents are don't-care and are never emitted. No VOUT is generated for the discarded partial group.
- SYNC=1 with VIN=1 in the same cycle: SYNC is applied first, so the sample is stored as slot0 and phase<=1.
- SYNC=1 at phase=2 with VIN=1: no group is emitted; the sample becomes the new slot0.
- RST_n low mid-group: all state and outputs clear immediately (asynchronously); the partial group is lost.
- No arithmetic; data passes through bit-exact. No backpressure (myfir has no ready), so the block cannot overflow.

Optional Feature:
Macro PACKER_FLUSH_EN.
- Defined: FLUSH input port exists.
  - FLUSH=1 with phase>0: emit the partial group with unfilled slots zeroed, then VOUT<=1, phase<=0.
    - phase=1: DOUT0=slot0, DOUT1=0, DOUT2=0.
    - phase=2: DOUT0=slot0, DOUT1=slot1, DOUT2=0.
  - FLUSH with VIN in the same cycle: the sample is placed first, then padded.
    - At phase=2 this is a normal full group.
    - At phase=0 this emits {DIN,0,0}.
  - FLUSH at phase=0 with VIN=0: no effect.
  - SYNC has priority over FLUSH.
- Undefined: no FLUSH port; partial groups wait indefinitely until completed, SYNC or reset.

Decomposition:
- Shared package fir_pkg:
  - constants NB=14, P=3
  - sample_t (signed [NB-1:0])
  - phase_t (2-bit) and its encodings PH0/PH1/PH2
- Single module, no sub-module. The phase counter is too small to justify one.

Test Plan:
- Reset then continuous VIN with DIN=1,2,3,4,5,6 -> VOUT pulses the cycle after samples 3 and 6, with DOUT0/1/2=1/2/3 then 4/5/6. VOUT is 0 in all other cycles.
- VIN gaps: DIN=10 (VIN=1), 2 idle cycles, 11, 1 idle cycle, 12 -> a single VOUT with 10/11/12. DOUTx keep their previous values throughout the gaps.
- SYNC at phase=2 together with VIN (DIN=7), then 8, 9 -> no output for the old partial group; next VOUT carries 7/8/9.
- RST_n pulsed low after 2 samples (asynchronous, mid-cycle) -> DOUTx=0 and VOUT=0 immediately. The next 3 samples 0x1FFF, 0x2000, 0x3FFF appear bit-exact.
- PACKER_FLUSH_EN, samples 5, 6 then FLUSH -> VOUT with 5/6/0. FLUSH at phase=0 with VIN=0 -> no VOUT.
- Long random stream of 3000 samples with random VIN duty -> the concatenated DOUT0,1,2 sequence equals the input sequence. VOUT count equals the number of samples / 3.
